// File: rtl/decoder_mb_pkg.sv
// Shared opcode constants and FSM encodings for the multi-byte instruction decoder.
package decoder_mb_pkg;

    localparam logic [4:0] LB5         = 5'b10110;
    localparam logic [2:0] LDST_OP     = 3'b111;
    localparam logic [0:0] DEC_IDLE    = 1'b0;
    localparam logic [0:0] DEC_COLLECT = 1'b1;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/decoder_mb_lb_collector.sv
// Collects LB operand bytes little-endian; flags the final byte and presents the full value.
module decoder_mb_lb_collector
    import decoder_mb_pkg::*;
#(
    parameter int IMM_BYTES = 1,
    parameter int DATA_LEN  = 8 * IMM_BYTES
) (
    input  logic                CLK,
    input  logic                RSTN,
    input  logic                start,
    input  logic                byte_vld,
    input  logic                flush,
    input  logic [7:0]          byte_in,
    output logic                done,
    output logic [DATA_LEN-1:0] value
);

    localparam int              CNT_W = cnt_width(IMM_BYTES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(IMM_BYTES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign done = byte_vld & (cnt_q == LAST);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (flush || start || done) cnt_d = '0;
        else if (byte_vld)          cnt_d = cnt_q + CNT_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    generate
        if (IMM_BYTES > 1) begin : g_acc
            logic [DATA_LEN-9:0] acc_q, acc_d;

            always_comb begin
                acc_d = acc_q;
                if (flush) begin
                    acc_d = '0;
                end else if (byte_vld && !done) begin
                    for (int i = 0; i < IMM_BYTES - 1; i++)
                        if (cnt_q == CNT_W'(i)) acc_d[8*i +: 8] = byte_in;
                end
            end

            // NOTE: acc is a small register bank, not a RAM, so it is cleared on reset.
            always_ff @(posedge CLK or negedge RSTN) begin
                if (!RSTN) acc_q <= '0;
                else       acc_q <= acc_d;
            end

            assign value = {byte_in, acc_q};
        end else begin : g_no_acc
            assign value = byte_in;
        end
    endgenerate

endmodule

// File: rtl/decoder_mb.sv
// 8-bit ISA decoder with multi-byte load-immediate, fetch-valid qualification and branch flush.
module decoder_mb
    import decoder_mb_pkg::*;
#(
    parameter int IMM_BYTES = 1,
    parameter int DATA_LEN  = 8 * IMM_BYTES,
    parameter int PC_LEN    = 7
) (
    input  logic                CLK,
    input  logic                RSTN,
    input  logic [7:0]          INSTR,
    input  logic                INSTR_VLD,
    input  logic                FLUSH,
    output logic [1:0]          ALU_OP,
    output logic [DATA_LEN-1:0] INSTR_IMM,
    output logic                IMM_SEL,
    output logic [PC_LEN-1:0]   BR_TARGET,
    output logic                IS_BR,
    output logic                IS_LD,
    output logic                IS_ST,
    output logic                LD_SEL,
    output logic [DATA_LEN-1:0] LB_IMM,
    output logic [1:0]          REG_ID,
    output logic                BUSY
);

    logic [0:0] state_q, state_d;
    logic [1:0] rid_q, rid_d;
    logic       lb_op, lds, lb_start, lb_byte_vld, lb_done;

    assign lb_op = (INSTR[7:3] == LB5);
    assign lds   = (INSTR[6:4] == LDST_OP);

    assign lb_start    = (state_q == DEC_IDLE)    & INSTR_VLD & lb_op & ~FLUSH;
    assign lb_byte_vld = (state_q == DEC_COLLECT) & INSTR_VLD & ~FLUSH;

    decoder_mb_lb_collector #(
        .IMM_BYTES (IMM_BYTES),
        .DATA_LEN  (DATA_LEN)
    ) u_lb_collector (
        .CLK      (CLK),
        .RSTN     (RSTN),
        .start    (lb_start),
        .byte_vld (lb_byte_vld),
        .flush    (FLUSH),
        .byte_in  (INSTR),
        .done     (lb_done),
        .value    (LB_IMM)
    );

    assign ALU_OP    = INSTR[5:4];
    assign INSTR_IMM = {{(DATA_LEN-4){INSTR[3]}}, INSTR[3:0]};
    assign IMM_SEL   = INSTR[6];
    assign BR_TARGET = INSTR[PC_LEN-1:0];
    assign REG_ID    = (state_q == DEC_COLLECT) ? rid_q : INSTR[1:0];

    always_comb begin
        state_d = state_q;
        rid_d   = rid_q;
        if (FLUSH) begin
            state_d = DEC_IDLE;
        end else if (lb_start) begin
            state_d = DEC_COLLECT;
            rid_d   = INSTR[1:0];
        end else if (lb_done) begin
            state_d = DEC_IDLE;
        end
    end

    // Strobes are held low through reset and flush; in COLLECT the byte is data only.
    always_comb begin
        IS_BR  = 1'b0;
        IS_LD  = 1'b0;
        IS_ST  = 1'b0;
        LD_SEL = 1'b0;
        BUSY   = 1'b0;
        if (RSTN && !FLUSH) begin
            if (state_q == DEC_COLLECT) begin
                BUSY   = 1'b1;
                IS_LD  = lb_done;
                LD_SEL = lb_done;
            end else if (INSTR_VLD && !lb_op) begin
                IS_LD = lds & ~INSTR[3];
                IS_ST = lds &  INSTR[3];
                IS_BR = INSTR[7];
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= DEC_IDLE;
            rid_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            rid_q   <= rid_d;
        end
    end

endmodule

// File: tb/tb_decoder_mb.sv
// Directed bench for decoder_mb at IMM_BYTES = 1, 2 and 4.
module tb_decoder_mb;

    logic       CLK = 1'b0;
    logic       RSTN = 1'b0;
    logic [7:0] instr [3];
    logic       vld   [3];
    logic       flush [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    // Instance 0: IMM_BYTES=1
    logic [1:0] a_alu, a_rid;
    logic [7:0] a_imm, a_lbimm;
    logic       a_isel, a_br, a_ld, a_st, a_ldsel, a_busy;
    logic [6:0] a_tgt;
    // Instance 1: IMM_BYTES=2
    logic [1:0]  b_alu, b_rid;
    logic [15:0] b_imm, b_lbimm;
    logic        b_isel, b_br, b_ld, b_st, b_ldsel, b_busy;
    logic [6:0]  b_tgt;
    // Instance 2: IMM_BYTES=4
    logic [1:0]  c_alu, c_rid;
    logic [31:0] c_imm, c_lbimm;
    logic        c_isel, c_br, c_ld, c_st, c_ldsel, c_busy;
    logic [6:0]  c_tgt;

    decoder_mb #(.IMM_BYTES(1)) u_dut1 (
        .CLK(CLK), .RSTN(RSTN), .INSTR(instr[0]), .INSTR_VLD(vld[0]), .FLUSH(flush[0]),
        .ALU_OP(a_alu), .INSTR_IMM(a_imm), .IMM_SEL(a_isel), .BR_TARGET(a_tgt),
        .IS_BR(a_br), .IS_LD(a_ld), .IS_ST(a_st), .LD_SEL(a_ldsel), .LB_IMM(a_lbimm),
        .REG_ID(a_rid), .BUSY(a_busy));

    decoder_mb #(.IMM_BYTES(2)) u_dut2 (
        .CLK(CLK), .RSTN(RSTN), .INSTR(instr[1]), .INSTR_VLD(vld[1]), .FLUSH(flush[1]),
        .ALU_OP(b_alu), .INSTR_IMM(b_imm), .IMM_SEL(b_isel), .BR_TARGET(b_tgt),
        .IS_BR(b_br), .IS_LD(b_ld), .IS_ST(b_st), .LD_SEL(b_ldsel), .LB_IMM(b_lbimm),
        .REG_ID(b_rid), .BUSY(b_busy));

    decoder_mb #(.IMM_BYTES(4)) u_dut4 (
        .CLK(CLK), .RSTN(RSTN), .INSTR(instr[2]), .INSTR_VLD(vld[2]), .FLUSH(flush[2]),
        .ALU_OP(c_alu), .INSTR_IMM(c_imm), .IMM_SEL(c_isel), .BR_TARGET(c_tgt),
        .IS_BR(c_br), .IS_LD(c_ld), .IS_ST(c_st), .LD_SEL(c_ldsel), .LB_IMM(c_lbimm),
        .REG_ID(c_rid), .BUSY(c_busy));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one byte into instance idx at the falling edge; others see bubbles.
    task automatic apply(input int idx, input logic [7:0] b, input logic v, input logic f);
        @(negedge CLK);
        for (int k = 0; k < 3; k++) begin
            instr[k] = 8'h00;
            vld[k]   = 1'b0;
            flush[k] = 1'b0;
        end
        instr[idx] = b;
        vld[idx]   = v;
        flush[idx] = f;
        #1;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            instr[k] = 8'hFF;
            vld[k]   = 1'b1;
            flush[k] = 1'b0;
        end

        // 1: reset with an all-ones valid byte
        #2;
        check("rst_strobes_1", {a_br, a_ld, a_st, a_ldsel, a_busy}, 0);
        check("rst_strobes_2", {b_br, b_ld, b_st, b_ldsel, b_busy}, 0);
        check("rst_strobes_4", {c_br, c_ld, c_st, c_ldsel, c_busy}, 0);
        @(negedge CLK);
        RSTN = 1'b1;
        apply(0, 8'h00, 1'b0, 1'b0);
        check("rel_busy_1", a_busy, 0);
        check("rel_busy_4", c_busy, 0);

        // 2: plain decode at IMM_BYTES=1
        apply(0, 8'h85, 1'b1, 1'b0);
        check("br_is_br", a_br, 1);
        check("br_target", a_tgt, 7'h05);
        check("br_ld_st", {a_ld, a_st}, 0);
        apply(0, 8'h79, 1'b1, 1'b0);
        check("st_is_st", a_st, 1);
        check("st_reg_id", a_rid, 1);
        check("st_other", {a_br, a_ld}, 0);
        check("st_alu_op", a_alu, 2'b11);
        apply(0, 8'h71, 1'b1, 1'b0);
        check("ld_is_ld", a_ld, 1);
        check("ld_ld_sel", a_ldsel, 0);
        check("ld_imm", a_imm, 8'h01);
        apply(0, 8'h4C, 1'b1, 1'b0);
        check("imm_sext", a_imm, 8'hFC);
        check("imm_sel", a_isel, 1);
        apply(0, 8'h85, 1'b0, 1'b0);
        check("bubble_no_br", a_br, 0);
        // LB at IMM_BYTES=1: opcode then one data byte
        apply(0, 8'hB3, 1'b1, 1'b0);
        check("lb1_op_strobes", {a_br, a_ld, a_st, a_busy}, 0);
        apply(0, 8'hA5, 1'b1, 1'b0);
        check("lb1_ld", {a_ld, a_ldsel, a_busy, a_br}, 4'b1110);
        check("lb1_value", a_lbimm, 8'hA5);
        check("lb1_reg_id", a_rid, 3);
        apply(0, 8'h00, 1'b0, 1'b0);
        check("lb1_idle", a_busy, 0);

        // 3: IMM_BYTES=2 with a bubble, then back-to-back decode
        apply(1, 8'hB2, 1'b1, 1'b0);
        check("lb2_op_reg", b_rid, 2);
        check("lb2_op_strobes", {b_br, b_ld, b_st, b_busy}, 0);
        apply(1, 8'h34, 1'b1, 1'b0);
        check("lb2_b0", {b_ld, b_ldsel, b_busy}, 3'b001);
        check("lb2_b0_reg", b_rid, 2);
        apply(1, 8'h00, 1'b0, 1'b0);
        check("lb2_bubble", {b_ld, b_ldsel, b_busy}, 3'b001);
        apply(1, 8'h12, 1'b1, 1'b0);
        check("lb2_done", {b_ld, b_ldsel, b_busy}, 3'b111);
        check("lb2_value", b_lbimm, 16'h1234);
        check("lb2_done_reg", b_rid, 2);
        apply(1, 8'h85, 1'b1, 1'b0);
        check("lb2_next_br", {b_br, b_busy}, 2'b10);

        // 5: opcode-looking operand bytes are data
        apply(1, 8'hB1, 1'b1, 1'b0);
        apply(1, 8'hB0, 1'b1, 1'b0);
        check("data_lb5", {b_br, b_ld, b_busy}, 3'b001);
        apply(1, 8'h85, 1'b1, 1'b0);
        check("data_85", {b_br, b_ld, b_ldsel}, 3'b011);
        check("data_value", b_lbimm, 16'h85B0);
        check("data_reg", b_rid, 1);
        apply(1, 8'h00, 1'b0, 1'b0);
        check("data_idle", b_busy, 0);

        // 4: flush mid-LB at IMM_BYTES=4
        apply(2, 8'hB0, 1'b1, 1'b0);
        apply(2, 8'h11, 1'b1, 1'b0);
        apply(2, 8'h22, 1'b1, 1'b0);
        check("fl_pre", {c_ld, c_busy}, 2'b01);
        apply(2, 8'h33, 1'b1, 1'b1);
        check("fl_strobes", {c_br, c_ld, c_st, c_ldsel, c_busy}, 0);
        apply(2, 8'h85, 1'b1, 1'b0);
        check("fl_br", {c_br, c_busy, c_ld}, 3'b100);
        apply(2, 8'hB1, 1'b1, 1'b0);
        apply(2, 8'h01, 1'b1, 1'b0);
        apply(2, 8'h02, 1'b1, 1'b0);
        apply(2, 8'h03, 1'b1, 1'b0);
        check("lb4_b2", {c_ld, c_busy}, 2'b01);
        apply(2, 8'h04, 1'b1, 1'b0);
        check("lb4_done", {c_ld, c_ldsel}, 2'b11);
        check("lb4_value", c_lbimm, 32'h04030201);
        check("lb4_reg", c_rid, 1);

        // 6: async reset mid-COLLECT
        apply(2, 8'hB0, 1'b1, 1'b0);
        apply(2, 8'h55, 1'b1, 1'b0);
        check("rst6_pre", c_busy, 1);
        @(posedge CLK);
        #3;
        RSTN = 1'b0;
        #1;
        check("rst6_busy", {c_busy, c_ld}, 0);
        @(negedge CLK);
        RSTN = 1'b1;
        apply(2, 8'h79, 1'b1, 1'b0);
        check("rst6_decode", {c_st, c_busy, c_ld}, 3'b100);
        check("rst6_reg", c_rid, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
